// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: state encoding,
// default line geometry and the port identifiers used for grants.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 28;
    localparam int MEM_DATA_W = 128;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin picker. A lone requester always wins; on a tie the
// port that did not win the previous tie is chosen.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_win,
    output logic win,
    output logic any
);

    // Pick the winner from the pending requests and the last tie winner
    always_comb begin
        win = PORT_I;
        any = req_i | req_d;
        if (req_i && req_d) begin
            win = ~last_win;
        end else if (req_d) begin
            win = PORT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one slow_memory line port between the I-cache and D-cache.
// Requests are serialised through IDLE -> WAIT -> DONE; the memory-side
// request is registered and held for the whole transfer, and the winning
// cache gets a single-cycle ready with the captured line.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              grant_d,
    output logic              timeout_err
);

    localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(TIMEOUT);

    arb_state_e        state_q, state_d;
    logic              last_win_q, last_win_d;
    logic              grant_d_q, grant_d_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [TO_W-1:0]   watchdog_q, watchdog_d;
    logic              timeout_err_q, timeout_err_d;

    logic pend_i;
    logic pend_d;
    logic win;
    logic any;

    assign pend_i = i_read | i_write;
    assign pend_d = d_read | d_write;

    mem_arb_rr_pick u_pick (
        .req_i    (pend_i),
        .req_d    (pend_d),
        .last_win (last_win_q),
        .win      (win),
        .any      (any)
    );

    // Next-state, grant capture, memory request and watchdog logic
    always_comb begin
        state_d       = state_q;
        last_win_d    = last_win_q;
        grant_d_d     = grant_d_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rdata_d       = rdata_q;
        watchdog_d    = watchdog_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d    = WAIT;
                    grant_d_d  = win;
                    watchdog_d = '0;
                    if (pend_i && pend_d) begin
                        last_win_d = win;
                    end
                    // A simultaneous read and write from one cache is a write
                    if (win == PORT_D) begin
                        mem_write_d = d_write;
                        mem_read_d  = ~d_write;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_write_d = i_write;
                        mem_read_d  = ~i_write;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = i_wdata;
                    end
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    rdata_d     = mem_write_q ? '0 : mem_rdata;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = DONE;
                end else begin
                    // Saturate so a stuck memory never wraps the counter
                    if (watchdog_q != TIMEOUT_V) begin
                        watchdog_d = watchdog_q + TO_W'(1);
                    end
                    if (watchdog_d == TIMEOUT_V) begin
                        timeout_err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                watchdog_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_win_q    <= PORT_I;
            grant_d_q     <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rdata_q       <= '0;
            watchdog_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_win_q    <= last_win_d;
            grant_d_q     <= grant_d_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_q       <= rdata_d;
            watchdog_q    <= watchdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign i_ready     = (state_q == DONE) && (grant_d_q == PORT_I);
    assign d_ready     = (state_q == DONE) && (grant_d_q == PORT_D);
    assign i_rdata     = i_ready ? rdata_q : '0;
    assign d_rdata     = d_ready ? rdata_q : '0;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign grant_d     = grant_d_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a behavioural slow memory,
// per-port requesters and a completion scoreboard.
module tb_mem_port_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        logic          port;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;

    typedef struct {
        logic [1:0]    i_op;
        logic [1:0]    d_op;
        logic [AW-1:0] i_addr;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] i_wdata;
        logic [DW-1:0] d_wdata;
        logic          first_d;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          i_read, i_write, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] i_wdata, d_wdata;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          i_ready, d_ready;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          grant_d;
    logic          timeout_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   ready_cyc = 0;
    int   mem_delay = 4;
    bit   mem_hold  = 0;
    exp_t exp_q[$];
    req_t i_q[$];
    req_t d_q[$];
    vec_t vecs[8];

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (1023),
        .TO_W    (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_read      (i_read),
        .i_write     (i_write),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_rdata     (i_rdata),
        .i_ready     (i_ready),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_ready     (d_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .grant_d     (grant_d),
        .timeout_err (timeout_err)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used for ready latency checks
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
        return {16'hDEAD, 4'h0, a, 48'h0123_4567_89AB, 4'h0, a, 16'hBEEF};
    endfunction

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_txn(input logic port, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] w);
        exp_t e;
        e.port = port; e.wr = wr; e.addr = a; e.wdata = w;
        exp_q.push_back(e);
    endtask

    task automatic add_req(input logic port, input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] w);
        req_t r;
        r.rd = op[0]; r.wr = op[1]; r.addr = a; r.wdata = w;
        if (port) d_q.push_back(r);
        else      i_q.push_back(r);
    endtask

    // Drive queued requests on both ports until every one has completed
    task automatic apply_stimulus(input int budget);
        bit i_on = 0;
        bit d_on = 0;
        int n = 0;
        while ((i_q.size() > 0 || d_q.size() > 0) && n < budget) begin
            if (n == 1) check_output("req_to_mem_latency", {127'b0, mem_read | mem_write}, 1);
            if (i_on && i_ready) begin
                void'(i_q.pop_front());
                i_read = 0; i_write = 0; i_on = 0;
            end else if (!i_on && i_q.size() > 0) begin
                i_read = i_q[0].rd; i_write = i_q[0].wr;
                i_addr = i_q[0].addr; i_wdata = i_q[0].wdata; i_on = 1;
            end
            if (d_on && d_ready) begin
                void'(d_q.pop_front());
                d_read = 0; d_write = 0; d_on = 0;
            end else if (!d_on && d_q.size() > 0) begin
                d_read = d_q[0].rd; d_write = d_q[0].wr;
                d_addr = d_q[0].addr; d_wdata = d_q[0].wdata; d_on = 1;
            end
            @(negedge clk);
            n++;
        end
        check_output("stimulus_budget", DW'(i_q.size() + d_q.size()), 0);
        i_q.delete(); d_q.delete();
        i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        i_read = 0; i_write = 0; d_read = 0; d_write = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    // Behavioural slow memory: checks the registered request and answers after mem_delay cycles
    initial begin
        logic          active;
        int            cnt;
        logic          h_rd, h_wr;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_wdata;
        active = 0; cnt = 0;
        mem_ready = 0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                mem_ready = 0; mem_rdata = '0; active = 0;
            end else if (mem_read || mem_write) begin
                if (!active) begin
                    active = 1; cnt = 0;
                    h_rd = mem_read; h_wr = mem_write; h_addr = mem_addr; h_wdata = mem_wdata;
                    if (exp_q.size() > 0) begin
                        check_output("mem_addr", mem_addr, exp_q[0].addr);
                        check_output("mem_write", {127'b0, mem_write}, {127'b0, exp_q[0].wr});
                        check_output("mem_read", {127'b0, mem_read}, {127'b0, ~exp_q[0].wr});
                        check_output("grant_d", {127'b0, grant_d}, {127'b0, exp_q[0].port});
                        if (exp_q[0].wr) check_output("mem_wdata", mem_wdata, exp_q[0].wdata);
                    end
                end else begin
                    check_output("mem_hold_addr", mem_addr, h_addr);
                    check_output("mem_hold_op", {126'b0, mem_read, mem_write}, {126'b0, h_rd, h_wr});
                    check_output("mem_hold_wdata", mem_wdata, h_wdata);
                end
                cnt++;
                if (!mem_hold && cnt >= mem_delay) begin
                    mem_ready = 1;
                    mem_rdata = line_of(mem_addr);
                    ready_cyc = cyc;
                end
            end else begin
                active = 0;
            end
        end
    end

    // Completion monitor: pops the scoreboard on every ready pulse
    initial begin
        logic prev_i, prev_d;
        exp_t e;
        prev_i = 0; prev_d = 0;
        forever begin
            @(negedge clk);
            check_output("mem_op_onehot", {127'b0, mem_read & mem_write}, 0);
            check_output("ready_onehot", {127'b0, i_ready & d_ready}, 0);
            if (prev_i) check_output("i_ready_pulse", {127'b0, i_ready}, 0);
            if (prev_d) check_output("d_ready_pulse", {127'b0, d_ready}, 0);
            if ((i_ready || d_ready) && !rst) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_ready", {126'b0, d_ready, i_ready}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("ready_port", {127'b0, d_ready}, {127'b0, e.port});
                    check_output("ready_latency", DW'(cyc), DW'(ready_cyc + 1));
                    if (d_ready) begin
                        check_output("d_rdata", d_rdata, e.wr ? '0 : line_of(e.addr));
                        check_output("loser_i_rdata", i_rdata, 0);
                    end else begin
                        check_output("i_rdata", i_rdata, e.wr ? '0 : line_of(e.addr));
                        check_output("loser_d_rdata", d_rdata, 0);
                    end
                end
            end
            prev_i = i_ready; prev_d = d_ready;
        end
    end

    // Absolute time limit so the run can never hang
    initial begin
        #200000;
        n_fail++;
        $display("[TB] FAIL global_timeout: simulation exceeded its time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $fatal(1, "[TB] aborted");
    end

    // Main test sequence
    initial begin
        int k;
        bit seen;

        vecs[0] = '{2'b01, 2'b00, 28'h0000010, 28'h0, '0, '0, 1'b0};
        vecs[1] = '{2'b00, 2'b10, 28'h0, 28'h0000020, '0, {16{8'hA5}}, 1'b1};
        vecs[2] = '{2'b01, 2'b01, 28'h0000030, 28'h0000040, '0, '0, 1'b1};
        vecs[3] = '{2'b01, 2'b01, 28'h0000050, 28'h0000060, '0, '0, 1'b0};
        vecs[4] = '{2'b10, 2'b01, 28'h0000070, 28'h0000080, {4{32'h1234_5678}}, '0, 1'b1};
        vecs[5] = '{2'b11, 2'b00, 28'h0000090, 28'h0, {8{16'hC3C3}}, '0, 1'b0};
        vecs[6] = '{2'b01, 2'b11, 28'h00000A0, 28'h00000B0, '0, {4{32'h0F0F_F0F0}}, 1'b0};
        vecs[7] = '{2'b10, 2'b10, 28'h00000C0, 28'h00000D0, {2{64'h0011_2233_4455_6677}}, {2{64'h8899_AABB_CCDD_EEFF}}, 1'b1};

        rst = 1;
        i_read = 0; i_write = 0; d_read = 0; d_write = 0;
        i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
        @(negedge clk);
        do_reset();

        check_output("rst_mem_read", {127'b0, mem_read}, 0);
        check_output("rst_mem_write", {127'b0, mem_write}, 0);
        check_output("rst_mem_addr", mem_addr, 0);
        check_output("rst_mem_wdata", mem_wdata, 0);
        check_output("rst_ready", {126'b0, i_ready, d_ready}, 0);
        check_output("rst_rdata", i_rdata | d_rdata, 0);
        check_output("rst_grant_d", {127'b0, grant_d}, 0);
        check_output("rst_timeout", {127'b0, timeout_err}, 0);

        // Table of single and simultaneous requests
        for (int v = 0; v < 8; v++) begin
            mem_delay = (v == 0) ? 4 : int'($urandom_range(1, 6));
            if (vecs[v].i_op != 0) add_req(1'b0, vecs[v].i_op, vecs[v].i_addr, vecs[v].i_wdata);
            if (vecs[v].d_op != 0) add_req(1'b1, vecs[v].d_op, vecs[v].d_addr, vecs[v].d_wdata);
            if (vecs[v].first_d && vecs[v].d_op != 0)
                expect_txn(1'b1, vecs[v].d_op[1], vecs[v].d_addr, vecs[v].d_wdata);
            if (vecs[v].i_op != 0)
                expect_txn(1'b0, vecs[v].i_op[1], vecs[v].i_addr, vecs[v].i_wdata);
            if (!vecs[v].first_d && vecs[v].d_op != 0)
                expect_txn(1'b1, vecs[v].d_op[1], vecs[v].d_addr, vecs[v].d_wdata);
            apply_stimulus(100);
            @(negedge clk);
        end

        // Stream: D requests three times while I stays pending -> D, I, D, D
        do_reset();
        mem_delay = 2;
        add_req(1'b0, 2'b01, 28'h0000100, '0);
        add_req(1'b1, 2'b01, 28'h0000200, '0);
        add_req(1'b1, 2'b01, 28'h0000210, '0);
        add_req(1'b1, 2'b01, 28'h0000220, '0);
        expect_txn(1'b1, 1'b0, 28'h0000200, '0);
        expect_txn(1'b0, 1'b0, 28'h0000100, '0);
        expect_txn(1'b1, 1'b0, 28'h0000210, '0);
        expect_txn(1'b1, 1'b0, 28'h0000220, '0);
        apply_stimulus(200);
        @(negedge clk);

        // Reset in the middle of a D read abandons it without a ready
        mem_hold = 1;
        d_read = 1; d_addr = 28'h00001F0;
        repeat (3) @(negedge clk);
        check_output("wait_mem_read", {127'b0, mem_read}, 1);
        rst = 1; d_read = 0;
        @(negedge clk);
        check_output("rst_wait_mem_read", {127'b0, mem_read}, 0);
        check_output("rst_wait_d_ready", {127'b0, d_ready}, 0);
        rst = 0; mem_hold = 0;
        @(negedge clk);
        check_output("post_rst_d_ready", {127'b0, d_ready}, 0);
        mem_delay = 3;
        add_req(1'b0, 2'b01, 28'h0000300, '0);
        expect_txn(1'b0, 1'b0, 28'h0000300, '0);
        apply_stimulus(100);
        @(negedge clk);

        // Watchdog: memory stalls 1100 WAIT cycles
        mem_hold = 1; mem_delay = 4;
        expect_txn(1'b1, 1'b0, 28'h00003C0, '0);
        d_read = 1; d_addr = 28'h00003C0;
        k = 0;
        for (int n = 0; n < 1200 && k < 1100; n++) begin
            @(negedge clk);
            if (mem_read) begin
                if (k == 1022) check_output("timeout_before", {127'b0, timeout_err}, 0);
                if (k == 1023) check_output("timeout_at", {127'b0, timeout_err}, 1);
                k++;
            end
        end
        check_output("timeout_wait_len", DW'(k), DW'(1100));
        check_output("timeout_sticky", {127'b0, timeout_err}, 1);
        mem_hold = 0;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (d_ready) begin
                seen = 1;
                d_read = 0;
            end
        end
        check_output("timeout_completes", {127'b0, seen}, 1);
        repeat (2) @(negedge clk);
        check_output("timeout_after_done", {127'b0, timeout_err}, 1);
        do_reset();
        check_output("timeout_cleared", {127'b0, timeout_err}, 0);

        check_output("scoreboard_empty", DW'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
